// File: rtl/mem_stage_if.sv
// Signal bundle between the ALU stage, the memory stage and the data-memory port.
// slave is the memory stage's view; master is the surrounding upstream/memory side.
interface mem_stage_if #(
    parameter int WD_SIZE     = 32,
    parameter int OPCODE_BITS = 7,
    parameter int FUNCT3_BITS = 3,
    parameter int REG_BITS    = 5
);
    logic                   in_valid;
    logic [OPCODE_BITS-1:0] opcode;
    logic [FUNCT3_BITS-1:0] funct3;
    logic [WD_SIZE-1:0]     alu_result;
    logic [WD_SIZE-1:0]     store_data;
    logic [REG_BITS-1:0]    rd_addr;
    logic                   stall;
    logic                   dmem_req;
    logic                   dmem_we;
    logic [WD_SIZE-1:0]     dmem_addr;
    logic [3:0]             dmem_be;
    logic [WD_SIZE-1:0]     dmem_wdata;
    logic                   dmem_ack;
    logic [WD_SIZE-1:0]     dmem_rdata;
    logic                   out_valid;
    logic                   out_wr_en;
    logic [REG_BITS-1:0]    out_rd;
    logic [WD_SIZE-1:0]     out_data;
    logic                   mem_exc;

    modport master (
        output in_valid, opcode, funct3, alu_result, store_data, rd_addr, dmem_ack, dmem_rdata,
        input  stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
               out_valid, out_wr_en, out_rd, out_data, mem_exc
    );

    modport slave (
        input  in_valid, opcode, funct3, alu_result, store_data, rd_addr, dmem_ack, dmem_rdata,
        output stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
               out_valid, out_wr_en, out_rd, out_data, mem_exc
    );
endinterface

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues loads/stores on a req/ack port with lane steering,
// passes other results through, and emits one registered writeback record per instruction.
module mem_stage #(
    parameter int WD_SIZE     = 32,
    parameter int OPCODE_BITS = 7,
    parameter int FUNCT3_BITS = 3,
    parameter int REG_BITS    = 5
) (
    input logic        clk,
    input logic        reset,
    mem_stage_if.slave bus
);
    localparam logic [OPCODE_BITS-1:0] OPCODE_LD = OPCODE_BITS'(7'b0000011);
    localparam logic [OPCODE_BITS-1:0] OPCODE_ST = OPCODE_BITS'(7'b0100011);
    localparam logic [OPCODE_BITS-1:0] OPCODE_OP = OPCODE_BITS'(7'b0110011);
    localparam logic [OPCODE_BITS-1:0] OPCODE_BR = OPCODE_BITS'(7'b1100011);
    localparam logic [OPCODE_BITS-1:0] OPCODE_JM = OPCODE_BITS'(7'b1101111);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state_q, state_d;
    logic                   req_q, req_d, we_q, we_d;
    logic [WD_SIZE-1:0]     addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]             be_q, be_d;
    logic [FUNCT3_BITS-1:0] f3_q, f3_d;
    logic [1:0]             off_q, off_d;
    logic [REG_BITS-1:0]    rd_q, rd_d;
    logic                   ov_q, ov_d, wen_q, wen_d, exc_q, exc_d;
    logic [REG_BITS-1:0]    ord_q, ord_d;
    logic [WD_SIZE-1:0]     odata_q, odata_d;

    logic               is_ld, is_st, f3_ok, align_ok, legal;
    logic [WD_SIZE-1:0] lane, ld_val;

    always_comb begin
        is_ld    = (bus.opcode == OPCODE_LD);
        is_st    = (bus.opcode == OPCODE_ST);
        f3_ok    = is_ld ? (bus.funct3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                         : (bus.funct3 inside {3'd0, 3'd1, 3'd2});
        align_ok = (bus.funct3[1:0] == 2'b01) ? !bus.alu_result[0] :
                   (bus.funct3[1:0] == 2'b10) ? (bus.alu_result[1:0] == 2'b00) : 1'b1;
        legal    = (state_q == IDLE) && bus.in_valid && (is_ld || is_st) && f3_ok && align_ok;
    end

    // Load lane extraction uses the byte offset captured at accept time.
    always_comb begin
        lane = bus.dmem_rdata >> {off_q, 3'b000};
        case (f3_q)
            3'd0:    ld_val = {{(WD_SIZE-8){lane[7]}}, lane[7:0]};
            3'd1:    ld_val = {{(WD_SIZE-16){lane[15]}}, lane[15:0]};
            3'd4:    ld_val = {{(WD_SIZE-8){1'b0}}, lane[7:0]};
            3'd5:    ld_val = {{(WD_SIZE-16){1'b0}}, lane[15:0]};
            default: ld_val = bus.dmem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        f3_d    = f3_q;
        off_d   = off_q;
        rd_d    = rd_q;
        ov_d    = 1'b0;
        wen_d   = 1'b0;
        exc_d   = 1'b0;
        ord_d   = ord_q;
        odata_d = odata_q;
        case (state_q)
            IDLE: begin
                if (legal) begin
                    state_d = BUSY;
                    req_d   = 1'b1;
                    we_d    = is_st;
                    addr_d  = {bus.alu_result[WD_SIZE-1:2], 2'b00};
                    f3_d    = bus.funct3;
                    off_d   = bus.alu_result[1:0];
                    rd_d    = bus.rd_addr;
                    case (bus.funct3[1:0])
                        2'b00: begin
                            be_d    = 4'b0001 << bus.alu_result[1:0];
                            wdata_d = {(WD_SIZE/8){bus.store_data[7:0]}};
                        end
                        2'b01: begin
                            be_d    = 4'b0011 << bus.alu_result[1:0];
                            wdata_d = {(WD_SIZE/16){bus.store_data[15:0]}};
                        end
                        default: begin
                            be_d    = 4'b1111;
                            wdata_d = bus.store_data;
                        end
                    endcase
                end else if (bus.in_valid) begin
                    ov_d    = 1'b1;
                    ord_d   = bus.rd_addr;
                    odata_d = bus.alu_result;
                    if (is_ld || is_st)
                        exc_d = 1'b1;
                    else
                        wen_d = (bus.opcode == OPCODE_OP || bus.opcode == OPCODE_JM)
                                && (bus.rd_addr != '0);
                end
            end
            BUSY: begin
                if (bus.dmem_ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                    ov_d    = 1'b1;
                    ord_d   = rd_q;
                    wen_d   = !we_q && (rd_q != '0);
                    if (!we_q)
                        odata_d = ld_val;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            f3_q    <= '0;
            off_q   <= '0;
            rd_q    <= '0;
            ov_q    <= 1'b0;
            wen_q   <= 1'b0;
            exc_q   <= 1'b0;
            ord_q   <= '0;
            odata_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            rd_q    <= rd_d;
            ov_q    <= ov_d;
            wen_q   <= wen_d;
            exc_q   <= exc_d;
            ord_q   <= ord_d;
            odata_q <= odata_d;
        end
    end

    assign bus.stall      = legal || ((state_q == BUSY) && !bus.dmem_ack);
    assign bus.dmem_req   = req_q;
    assign bus.dmem_we    = we_q;
    assign bus.dmem_addr  = addr_q;
    assign bus.dmem_be    = be_q;
    assign bus.dmem_wdata = wdata_q;
    assign bus.out_valid  = ov_q;
    assign bus.out_wr_en  = wen_q;
    assign bus.out_rd     = ord_q;
    assign bus.out_data   = odata_q;
    assign bus.mem_exc    = exc_q;
endmodule
